// File: rtl/immediate_encoder_if.sv
// Valid/ready bundle between an instruction sequencer (master) and immediate_encoder (slave).
interface immediate_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [2:0]        fmt_i;
    logic [6:0]        opcode_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [2:0]        funct3_i;
    logic [31:0]       imm_i;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] addr_o;
    logic              err_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              full_o;

    modport master (
        output in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, imm_i, out_ready_i,
        input  in_ready_o, instr_o, addr_o, err_o, out_valid_o, full_o
    );

    modport slave (
        input  in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, imm_i, out_ready_i,
        output in_ready_o, instr_o, addr_o, err_o, out_valid_o, full_o
    );
endinterface

// File: rtl/immediate_encoder.sv
// Streaming RISC-V I/S/B/U/J instruction assembler with one output register stage.
// Optional immediate range checking is built only when IMM_RANGE_CHECK_EN is defined.
module immediate_encoder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    immediate_encoder_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {RUN, FULL} state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     count;
    logic [CW-1:0]     next_index;
    logic              out_valid;
    logic              err_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] addr_q;
    logic              room;
    logic              in_ready;
    logic              in_hs;
    logic              out_hs;
    logic [31:0]       imm;
    logic [31:0]       enc_word;
    logic              fmt_bad;
    logic              range_bad;

    assign imm    = bus.imm_i;
    assign out_hs = out_valid && bus.out_ready_i;

    // The word being accepted is either the next one to emit (register empty) or
    // the one after the word leaving this cycle; stop once DEPTH words are taken.
    assign next_index = count + CW'(out_valid);
    assign room       = (next_index != CW'(DEPTH));
    assign in_ready   = (state == RUN) && !clear_i && room && (!out_valid || bus.out_ready_i);
    assign in_hs      = bus.in_valid_i && in_ready;

    always_comb begin
        enc_word = 32'h0000_0013;
        fmt_bad  = 1'b0;
        case (bus.fmt_i)
            3'd0: enc_word = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, bus.opcode_i};
            3'd1: enc_word = {imm[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:0], bus.opcode_i};
            3'd2: enc_word = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                              imm[4:1], imm[11], bus.opcode_i};
            3'd3: enc_word = {imm[31:12], bus.rd_i, bus.opcode_i};
            3'd4: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd_i, bus.opcode_i};
            default: fmt_bad = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Representable means every bit above the format's sign bit copies it.
    always_comb begin
        range_bad = 1'b0;
        case (bus.fmt_i)
            3'd0, 3'd1: range_bad = !((&imm[31:11]) || !(|imm[31:11]));
            3'd2:       range_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            3'd3:       range_bad = |imm[11:0];
            3'd4:       range_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            default:    range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (out_hs && (count == CW'(DEPTH - 1))) state_next = FULL;
            FULL:    state_next = FULL;
            default: state_next = RUN;
        endcase
        if (clear_i) state_next = RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear_i) begin
            count <= '0;
        end else if (out_hs) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            instr_q   <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
        end else if (clear_i) begin
            out_valid <= 1'b0;
        end else if (in_hs) begin
            out_valid <= 1'b1;
            instr_q   <= enc_word;
            addr_q    <= ADDR_W'(next_index) << 2;
            err_q     <= fmt_bad || range_bad;
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.instr_o     = instr_q;
    assign bus.addr_o      = addr_q;
    assign bus.err_o       = err_q;
    assign bus.full_o      = (state == FULL);
endmodule

// File: tb/tb_immediate_encoder.sv
// Self-checking bench for immediate_encoder: directed test-plan cases plus a randomized
// stream scored against an arithmetic reference encoder.
module tb_immediate_encoder;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } word_t;

    logic clk;
    logic reset;
    logic clear;
    int   tests_run;
    int   tests_failed;

    immediate_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    immediate_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: fields placed with shifts and masks; range judged on the signed value.
    function automatic logic [32:0] ref_encode(input logic [2:0] fmt, input logic [6:0] op,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [2:0] f3,
                                               input logic [31:0] imm);
        logic [31:0] w;
        logic        bad;
        int          v;
        v   = signed'(imm);
        w   = 32'h0000_0013;
        bad = 1'b0;
        case (fmt)
            3'd0: begin
                w   = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
                bad = (v < -2048) || (v > 2047);
            end
            3'd1: begin
                w   = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                    | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
                bad = (v < -2048) || (v > 2047);
            end
            3'd2: begin
                w   = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
                    | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 32'h1) << 7) | 32'(op);
                bad = (v < -4096) || (v > 4095) || ((imm & 32'h1) != 0);
            end
            3'd3: begin
                w   = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
                bad = (imm & 32'hFFF) != 0;
            end
            3'd4: begin
                w   = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                    | (32'(rd) << 7) | 32'(op);
                bad = (v < -1048576) || (v > 1048575) || ((imm & 32'h1) != 0);
            end
            default: begin
                w   = 32'h0000_0013;
                bad = 1'b1;
            end
        endcase
        if (fmt > 3'd4) return {1'b1, w};
        return {RANGE_EN && bad, w};
    endfunction

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [31:0] imm);
        bus.in_valid_i = 1'b1;
        bus.fmt_i      = fmt;
        bus.opcode_i   = op;
        bus.rd_i       = rd;
        bus.rs1_i      = rs1;
        bus.rs2_i      = rs2;
        bus.funct3_i   = f3;
        bus.imm_i      = imm;
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        tests_run++;
        if (bus.in_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready_o); end
        tests_run++;
        if (bus.out_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid_o); end
        tests_run++;
        if (bus.instr_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_instr: got %h expected 0", bus.instr_o); end
        tests_run++;
        if (bus.addr_o !== 8'h0 || bus.err_o !== 1'b0 || bus.full_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_addr_err_full: got %h/%b/%b expected 00/0/0", bus.addr_o, bus.err_o, bus.full_o);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_i_format();
        do_clear();
        bus.out_ready_i = 1'b0;
        drive(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
        #1;
        tests_run++;
        if (bus.in_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL i_in_ready: got %b expected 1", bus.in_ready_o); end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid_o !== 1'b1 || bus.instr_o !== 32'hFFF0_0093 || bus.addr_o !== 8'h00 || bus.err_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL i_word: got v=%b %h @%h e=%b expected v=1 fff00093 @00 e=0",
                     bus.out_valid_o, bus.instr_o, bus.addr_o, bus.err_o);
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL i_drain: got %b expected 0", bus.out_valid_o); end
    endtask

    task automatic test_back_to_back();
        do_clear();
        bus.out_ready_i = 1'b1;
        drive(3'd1, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 32'd8);
        @(negedge clk);
        drive(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
        #1;
        tests_run++;
        if (bus.in_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_in_ready: got %b expected 1", bus.in_ready_o); end
        tests_run++;
        if (bus.out_valid_o !== 1'b1 || bus.instr_o !== 32'h0021_A423 || bus.addr_o !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL b2b_s_word: got v=%b %h @%h expected v=1 0021a423 @00", bus.out_valid_o, bus.instr_o, bus.addr_o);
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid_o !== 1'b1 || bus.instr_o !== 32'h1234_52B7 || bus.addr_o !== 8'h04 || bus.err_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_u_word: got v=%b %h @%h e=%b expected v=1 123452b7 @04 e=0",
                     bus.out_valid_o, bus.instr_o, bus.addr_o, bus.err_o);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (bus.out_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_drain: got %b expected 0", bus.out_valid_o); end
    endtask

    task automatic test_b_format();
        do_clear();
        bus.out_ready_i = 1'b0;
        drive(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.instr_o !== 32'hFE00_0EE3 || bus.err_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b_word: got %h e=%b expected fe000ee3 e=0", bus.instr_o, bus.err_o);
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
    endtask

    task automatic test_faults();
        do_clear();
        bus.out_ready_i = 1'b1;
        drive(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
        @(negedge clk);
        drive(3'd6, 7'h33, 5'd9, 5'd4, 5'd7, 3'd5, 32'h0000_0044);
        #1;
        tests_run++;
        if (bus.instr_o !== 32'h8000_0093 || bus.err_o !== RANGE_EN) begin
            tests_failed++;
            $display("[TB] FAIL fault_i_range: got %h e=%b expected 80000093 e=%b", bus.instr_o, bus.err_o, RANGE_EN);
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.instr_o !== 32'h0000_0013 || bus.err_o !== 1'b1 || bus.addr_o !== 8'h04) begin
            tests_failed++;
            $display("[TB] FAIL fault_fmt: got %h e=%b @%h expected 00000013 e=1 @04", bus.instr_o, bus.err_o, bus.addr_o);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [32:0] ra;
        logic [32:0] rb;
        ra = ref_encode(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'hABCD_E000);
        rb = ref_encode(3'd0, 7'h13, 5'd2, 5'd7, 5'd0, 3'd0, 32'h0000_0123);
        do_clear();
        bus.out_ready_i = 1'b0;
        drive(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'hABCD_E000);
        @(negedge clk);
        drive(3'd0, 7'h13, 5'd2, 5'd7, 5'd0, 3'd0, 32'h0000_0123);
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (bus.out_valid_o !== 1'b1 || bus.instr_o !== ra[31:0] || bus.addr_o !== 8'h00 || bus.in_ready_o !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL bp_hold%0d: got v=%b %h @%h rdy=%b expected v=1 %h @00 rdy=0",
                         k, bus.out_valid_o, bus.instr_o, bus.addr_o, bus.in_ready_o, ra[31:0]);
            end
            @(negedge clk);
        end
        bus.out_ready_i = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_release: got %b expected 1", bus.in_ready_o); end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.instr_o !== rb[31:0] || bus.addr_o !== 8'h04) begin
            tests_failed++;
            $display("[TB] FAIL bp_second: got %h @%h expected %h @04", bus.instr_o, bus.addr_o, rb[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_full_and_clear();
        logic [32:0] exp_r [5];
        for (int i = 0; i < 5; i++) exp_r[i] = ref_encode(3'd0, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 32'(i * 16));
        do_clear();
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(3'd0, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 32'(i * 16));
            #1;
            tests_run++;
            if (bus.in_ready_o !== (i < DEPTH)) begin
                tests_failed++;
                $display("[TB] FAIL full_ready%0d: got %b expected %b", i, bus.in_ready_o, (i < DEPTH));
            end
            if (i > 0) begin
                tests_run++;
                if (bus.out_valid_o !== 1'b1 || bus.addr_o !== ADDR_W'((i - 1) * 4) || bus.instr_o !== exp_r[i-1][31:0]) begin
                    tests_failed++;
                    $display("[TB] FAIL full_word%0d: got v=%b %h @%h expected v=1 %h @%h",
                             i - 1, bus.out_valid_o, bus.instr_o, bus.addr_o, exp_r[i-1][31:0], ADDR_W'((i - 1) * 4));
                end
            end
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            tests_run++;
            if (bus.full_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL full_state%0d: got full=%b v=%b rdy=%b expected 1/0/0",
                         k, bus.full_o, bus.out_valid_o, bus.in_ready_o);
            end
            @(negedge clk);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        tests_run++;
        if (bus.full_o !== 1'b0 || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL clear_state: got full=%b v=%b rdy=%b expected 0/0/1", bus.full_o, bus.out_valid_o, bus.in_ready_o);
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid_o !== 1'b1 || bus.addr_o !== 8'h00 || bus.instr_o !== exp_r[4][31:0]) begin
            tests_failed++;
            $display("[TB] FAIL clear_next: got v=%b %h @%h expected v=1 %h @00", bus.out_valid_o, bus.instr_o, bus.addr_o, exp_r[4][31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_random_stream();
        word_t       exp_q[$];
        word_t       w;
        int          accepted;
        int          emitted;
        logic        exp_ready;
        logic [32:0] r;
        logic [31:0] imm;
        for (int round = 0; round < 6; round++) begin
            do_clear();
            exp_q.delete();
            accepted = 0;
            emitted  = 0;
            for (int cyc = 0; cyc < 30; cyc++) begin
                case ($urandom_range(0, 3))
                    0:       imm = $urandom;
                    1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                    2:       imm = $urandom & 32'hFFFF_F000;
                    default: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
                endcase
                drive(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                      5'($urandom), 3'($urandom), imm);
                bus.in_valid_i  = ($urandom_range(0, 3) != 0);
                bus.out_ready_i = ($urandom_range(0, 2) != 0);
                #1;
                exp_ready = (accepted < DEPTH) && ((exp_q.size() == 0) || bus.out_ready_i);
                tests_run++;
                if (bus.out_valid_o !== (exp_q.size() != 0)) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_valid r%0d c%0d: got %b expected %b", round, cyc, bus.out_valid_o, (exp_q.size() != 0));
                end
                tests_run++;
                if (bus.in_ready_o !== exp_ready) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_ready r%0d c%0d: got %b expected %b", round, cyc, bus.in_ready_o, exp_ready);
                end
                tests_run++;
                if (bus.full_o !== (emitted == DEPTH)) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_full r%0d c%0d: got %b expected %b", round, cyc, bus.full_o, (emitted == DEPTH));
                end
                if (exp_q.size() != 0) begin
                    tests_run++;
                    if (bus.instr_o !== exp_q[0].instr || bus.addr_o !== exp_q[0].addr || bus.err_o !== exp_q[0].err) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_word r%0d c%0d: got %h @%h e=%b expected %h @%h e=%b", round, cyc,
                                 bus.instr_o, bus.addr_o, bus.err_o, exp_q[0].instr, exp_q[0].addr, exp_q[0].err);
                    end
                end
                if ((exp_q.size() != 0) && bus.out_ready_i) begin
                    void'(exp_q.pop_front());
                    emitted++;
                end
                if (bus.in_valid_i && exp_ready) begin
                    r = ref_encode(bus.fmt_i, bus.opcode_i, bus.rd_i, bus.rs1_i, bus.rs2_i, bus.funct3_i, bus.imm_i);
                    w.instr = r[31:0];
                    w.err   = r[32];
                    w.addr  = ADDR_W'(accepted * 4);
                    exp_q.push_back(w);
                    accepted++;
                end
                @(negedge clk);
            end
            bus.in_valid_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] rz;
        rz = ref_encode(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
        do_clear();
        bus.out_ready_i = 1'b1;
        drive(3'd0, 7'h13, 5'd3, 5'd3, 5'd0, 3'd0, 32'h0000_0001);
        @(negedge clk);
        drive(3'd0, 7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 32'h0000_0002);
        @(negedge clk);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid_o !== 1'b1 || bus.addr_o !== 8'h04) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_pre: got v=%b @%h expected v=1 @04", bus.out_valid_o, bus.addr_o);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid_o !== 1'b0 || bus.addr_o !== 8'h00 || bus.instr_o !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_async: got v=%b %h @%h expected v=0 00000000 @00", bus.out_valid_o, bus.instr_o, bus.addr_o);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid_o !== 1'b1 || bus.addr_o !== 8'h00 || bus.instr_o !== rz[31:0] || bus.err_o !== rz[32]) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_next: got v=%b %h @%h e=%b expected v=1 %h @00 e=%b",
                     bus.out_valid_o, bus.instr_o, bus.addr_o, bus.err_o, rz[31:0], rz[32]);
        end
        @(negedge clk);
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        reset           = 1'b0;
        clear           = 1'b0;
        bus.out_ready_i = 1'b0;
        drive(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        bus.in_valid_i  = 1'b0;
        test_reset();
        test_i_format();
        test_back_to_back();
        test_b_format();
        test_faults();
        test_backpressure();
        test_full_and_clear();
        test_random_stream();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
